player_core: RTL and testbench

- Executes the player instructions issued by the game-state controller.
- Decodes `playerInstruction` = {op[15:12], arg[11:4], pad[3:0]}, qualified by `isMove` and `startDmg`.
- Maintains player HP, on-screen position and invulnerability timing, and reports death back to the controller.
- Sits between the game-state controller and the renderer/collision logic.

---
 rtl/player_core_if.sv | 23 ++
 rtl/player_core.sv | 172 +++++++++++++++++
 tb/tb_player_core.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/player_core_if.sv
// Controller <-> player_core bundle: instruction/strobe inputs and player status outputs.
interface player_core_if;
  logic [15:0] playerInstruction;
  logic        isMove;
  logic        startDmg;
  logic [7:0]  hp;
  logic [9:0]  posX;
  logic [9:0]  posY;
  logic        isDeath;
  logic        isInvuln;
  logic        dmgAck;
  logic        visible;

  modport master (
    output playerInstruction, isMove, startDmg,
    input  hp, posX, posY, isDeath, isInvuln, dmgAck, visible
  );

  modport slave (
    input  playerInstruction, isMove, startDmg,
    output hp, posX, posY, isDeath, isInvuln, dmgAck, visible
  );
endinterface

// File: rtl/player_core.sv
// Player HP / position / invulnerability state machine driven by controller instructions.
// Optional sprite blinking during i-frames is enabled with `define PLAYER_BLINK_EN.
module player_core #(
  parameter logic [7:0] HP_MAX        = 8'd100,
  parameter int         X_MIN         = 16,
  parameter int         X_MAX         = 624,
  parameter int         Y_MIN         = 16,
  parameter int         Y_MAX         = 464,
  parameter int         X_INIT        = 320,
  parameter int         Y_INIT        = 240,
  parameter int         STEP          = 4,
  parameter int         MOVE_DIV      = 250000,
  parameter int         IFRAME_CYCLES = 50000000,
  parameter int         BLINK_SHIFT   = 22
) (
  input  logic           clk,
  input  logic           rst_n,
  player_core_if.slave   bus
);

  localparam int TW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int IW = (IFRAME_CYCLES > 1) ? $clog2(IFRAME_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(MOVE_DIV - 1);
  localparam logic [IW-1:0] IFR_LOAD  = IW'(IFRAME_CYCLES - 1);
  localparam logic [10:0]   STEP11    = 11'(STEP);

  localparam logic [3:0] OP_HPY = 4'd1;
  localparam logic [3:0] OP_DPY = 4'd2;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_SHP = 4'd6;

  typedef enum logic [1:0] {ALIVE, HIT, DEAD} state_t;

  state_t          state, nxt_state;
  logic [7:0]      hp_q, nxt_hp;
  logic [IW-1:0]   ifr, nxt_ifr;
  logic [TW-1:0]   tick;
  logic [9:0]      pos_x, pos_y;
  logic            death_q, invuln_q, ack_q;
  logic [3:0]      op;
  logic [7:0]      arg;
  logic            move_en;
  logic [8:0]      diff9, sum9;
  logic            unused_pad;

  assign op         = bus.playerInstruction[15:12];
  assign arg        = bus.playerInstruction[11:4];
  assign unused_pad = ^bus.playerInstruction[3:0];

  // Saturating one-step move; 11-bit intermediate keeps underflow visible in bit 10.
  function automatic logic [9:0] step_pos(input logic [9:0] p, input logic inc,
                                          input logic [10:0] lo, input logic [10:0] hi);
    logic [10:0] s;
    if (inc) begin
      s = {1'b0, p} + STEP11;
      if (s > hi) s = hi;
    end else begin
      s = {1'b0, p} - STEP11;
      if (s[10] || (s < lo)) s = lo;
    end
    return s[9:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n)                tick <= '0;
    else if (tick == TICK_LAST) tick <= '0;
    else                       tick <= tick + TW'(1);
  end

  assign move_en = (tick == TICK_LAST) && bus.isMove && (op == OP_MOV) &&
                   !bus.startDmg && (state != DEAD);

  always_comb begin
    nxt_state = state;
    nxt_hp    = hp_q;
    nxt_ifr   = ifr;
    diff9     = {1'b0, hp_q} - {1'b0, arg};
    sum9      = {1'b0, hp_q} + {1'b0, arg};

    if (state == HIT) begin
      if (ifr == '0) nxt_state = ALIVE;
      else           nxt_ifr   = ifr - IW'(1);
    end

    if (bus.startDmg) begin
      case (op)
        OP_DPY: if (state == ALIVE) begin
          nxt_hp = diff9[8] ? 8'd0 : diff9[7:0];
          if (nxt_hp == 8'd0) begin
            nxt_state = DEAD;
            nxt_ifr   = '0;
          end else begin
            nxt_state = HIT;
            nxt_ifr   = IFR_LOAD;
          end
        end
        OP_HPY: if (state != DEAD)
          nxt_hp = (sum9 > {1'b0, HP_MAX}) ? HP_MAX : sum9[7:0];
        OP_SHP: begin
          nxt_hp  = (arg > HP_MAX) ? HP_MAX : arg;
          nxt_ifr = '0;
          nxt_state = (arg != 8'd0) ? ALIVE : DEAD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ALIVE;
      hp_q     <= HP_MAX;
      ifr      <= '0;
      pos_x    <= 10'(X_INIT);
      pos_y    <= 10'(Y_INIT);
      death_q  <= 1'b0;
      invuln_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state    <= nxt_state;
      hp_q     <= nxt_hp;
      ifr      <= nxt_ifr;
      death_q  <= (nxt_state == DEAD);
      invuln_q <= (nxt_state == HIT);
      ack_q    <= bus.startDmg;
      if (move_en) begin
        case (arg)
          8'd0: pos_y <= step_pos(pos_y, 1'b0, 11'(Y_MIN), 11'(Y_MAX));
          8'd1: pos_x <= step_pos(pos_x, 1'b0, 11'(X_MIN), 11'(X_MAX));
          8'd2: pos_y <= step_pos(pos_y, 1'b1, 11'(Y_MIN), 11'(Y_MAX));
          8'd3: pos_x <= step_pos(pos_x, 1'b1, 11'(X_MIN), 11'(X_MAX));
          default: ;
        endcase
      end
    end
  end

`ifdef PLAYER_BLINK_EN
  logic [BLINK_SHIFT:0] blink, nxt_blink;
  logic                 vis_q;

  // Counter restarts at 0 on HIT entry so the first half-period is dark.
  always_comb begin
    nxt_blink = '0;
    if (nxt_state == HIT && state == HIT) nxt_blink = blink + (BLINK_SHIFT+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink <= '0;
      vis_q <= 1'b1;
    end else begin
      blink <= nxt_blink;
      if (nxt_state == HIT) vis_q <= nxt_blink[BLINK_SHIFT];
      else                  vis_q <= (nxt_state != DEAD);
    end
  end

  assign bus.visible = vis_q;
`else
  localparam int blink_shift_unused = BLINK_SHIFT;
  assign bus.visible = 1'b1;
`endif

  assign bus.hp       = hp_q;
  assign bus.posX     = pos_x;
  assign bus.posY     = pos_y;
  assign bus.isDeath  = death_q;
  assign bus.isInvuln = invuln_q;
  assign bus.dmgAck   = ack_q;

endmodule

// File: tb/tb_player_core.sv
// Directed scoreboard bench for player_core: expectations queued at drive time, checked after the edge.
module tb_player_core;
  localparam int MOVE_DIV = 4;
  localparam int STEP     = 4;
  localparam int IFR      = 16;
  localparam int BS       = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  player_core_if bus();

  player_core #(
    .MOVE_DIV(MOVE_DIV), .STEP(STEP), .IFRAME_CYCLES(IFR), .BLINK_SHIFT(BS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [7:0] hp;
    logic [9:0] x;
    logic [9:0] y;
    logic       death;
    logic       inv;
    logic       ack;
    logic       vis;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;
  int    px = 320;
  int    py = 240;

  function automatic obs_t mk(input int h, input int x, input int y,
                              input logic d, input logic i, input logic a, input logic v);
    obs_t e;
    e.hp = 8'(h); e.x = 10'(x); e.y = 10'(y);
    e.death = d; e.inv = i; e.ack = a; e.vis = v;
    return e;
  endfunction

  // Expected sprite enable k cycles after HIT entry (k=0 is the entry cycle).
  function automatic logic vis_hit(input int k);
`ifdef PLAYER_BLINK_EN
    return 1'((k >> BS) & 1);
`else
    return 1'b1 | 1'(k & 0);
`endif
  endfunction

  function automatic logic vis_dead();
`ifdef PLAYER_BLINK_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic push(input string t, input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic pop_check();
    obs_t e, o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o.hp = bus.hp; o.x = bus.posX; o.y = bus.posY;
    o.death = bus.isDeath; o.inv = bus.isInvuln; o.ack = bus.dmgAck; o.vis = bus.visible;
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed hp=%0d x=%0d y=%0d death=%b inv=%b ack=%b vis=%b, expected hp=%0d x=%0d y=%0d death=%b inv=%b ack=%b vis=%b",
             t, o.hp, o.x, o.y, o.death, o.inv, o.ack, o.vis,
             e.hp, e.x, e.y, e.death, e.inv, e.ack, e.vis);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [15:0] ins, input logic mv, input string t, input obs_t e);
    bus.playerInstruction = ins;
    bus.isMove = mv;
    bus.startDmg = 1'b1;
    push(t, e);
    cyc(1);
    bus.startDmg = 1'b0;
    bus.isMove = 1'b0;
    pop_check();
  endtask

  task automatic hold(input logic [15:0] ins, input logic mv, input int n,
                      input string t, input obs_t e);
    bus.playerInstruction = ins;
    bus.isMove = mv;
    push(t, e);
    cyc(n);
    bus.isMove = 1'b0;
    pop_check();
  endtask

  initial begin
    bus.playerInstruction = 16'h0000;
    bus.isMove = 1'b0;
    bus.startDmg = 1'b0;

    // Reset
    push("reset", mk(100, 320, 240, 0, 0, 0, 1));
    cyc(2);
    pop_check();
    rst_n = 1'b1;

    // Movement and saturation at every edge
    hold(16'h5030, 1, 8,   "mov_right8", mk(100, 328, 240, 0, 0, 0, 1));
    hold(16'h5030, 1, 300, "sat_xmax",   mk(100, 624, 240, 0, 0, 0, 1));
    hold(16'h5000, 1, 300, "sat_ymin",   mk(100, 624, 16,  0, 0, 0, 1));
    hold(16'h5010, 1, 700, "sat_xmin",   mk(100, 16,  16,  0, 0, 0, 1));
    hold(16'h5020, 1, 500, "sat_ymax",   mk(100, 16,  464, 0, 0, 0, 1));
    hold(16'h5040, 1, 8,   "mov_badarg", mk(100, 16,  464, 0, 0, 0, 1));
    hold(16'h5030, 0, 8,   "mov_nomove", mk(100, 16,  464, 0, 0, 0, 1));
    px = 16; py = 464;

    // Damage, ignored re-hit, i-frame expiry after 16 cycles
    strobe(16'h21E0, 0, "dpy30",      mk(70, px, py, 0, 1, 1, vis_hit(0)));
    hold(16'h0000, 0, 4, "hit_idle",  mk(70, px, py, 0, 1, 0, vis_hit(4)));
    strobe(16'h21E0, 0, "dpy_in_hit", mk(70, px, py, 0, 1, 1, vis_hit(5)));
    hold(16'h0000, 0, 10, "hit_last", mk(70, px, py, 0, 1, 0, vis_hit(15)));
    hold(16'h0000, 0, 1,  "hit_exit", mk(70, px, py, 0, 0, 0, 1));

    // Death and recovery
    strobe(16'h2C80, 0, "dpy200_dead", mk(0, px, py, 1, 0, 1, vis_dead()));
    hold(16'h5000, 1, 8, "dead_mov",   mk(0, px, py, 1, 0, 0, vis_dead()));
    strobe(16'h10A0, 0, "dead_hpy",    mk(0, px, py, 1, 0, 1, vis_dead()));
    strobe(16'h2050, 0, "dead_dpy",    mk(0, px, py, 1, 0, 1, vis_dead()));
    strobe(16'h6640, 0, "shp100",      mk(100, px, py, 0, 0, 1, 1));
    strobe(16'h3140, 0, "nop_idg",     mk(100, px, py, 0, 0, 1, 1));
    strobe(16'h6C80, 0, "shp_clamp",   mk(100, px, py, 0, 0, 1, 1));
    strobe(16'h6000, 0, "shp0_dead",   mk(0, px, py, 1, 0, 1, vis_dead()));
    strobe(16'h6320, 0, "shp50",       mk(50, px, py, 0, 0, 1, 1));
    strobe(16'h2000, 0, "dpy0_hit",    mk(50, px, py, 0, 1, 1, vis_hit(0)));
    strobe(16'h6640, 0, "shp_in_hit",  mk(100, px, py, 0, 0, 1, 1));

    // Heal in HIT with a concurrent move request; strobed MOV suppresses the move
    strobe(16'h2050, 0, "dpy5",        mk(95, px, py, 0, 1, 1, vis_hit(0)));
    strobe(16'h10A0, 1, "hpy_hit_mv",  mk(100, px, py, 0, 1, 1, vis_hit(1)));
    bus.playerInstruction = 16'h5030;
    bus.isMove = 1'b1;
    bus.startDmg = 1'b1;
    push("strobe_mov_sup", mk(100, px, py, 0, 1, 1, vis_hit(5)));
    cyc(4);
    bus.startDmg = 1'b0;
    bus.isMove = 1'b0;
    pop_check();
    hold(16'h0000, 0, 10, "hit2_last", mk(100, px, py, 0, 1, 0, vis_hit(15)));
    hold(16'h0000, 0, 1,  "hit2_exit", mk(100, px, py, 0, 0, 0, 1));

    // Per-cycle visibility across a full HIT window
    strobe(16'h2010, 0, "dpy1", mk(99, px, py, 0, 1, 1, vis_hit(0)));
    for (int k = 1; k < IFR; k++)
      hold(16'h0000, 0, 1, "blink", mk(99, px, py, 0, 1, 0, vis_hit(k)));
    hold(16'h0000, 0, 1, "blink_exit", mk(99, px, py, 0, 0, 0, 1));

    // Reset in the middle of an i-frame
    strobe(16'h20A0, 0, "dpy10", mk(89, px, py, 0, 1, 1, vis_hit(0)));
    rst_n = 1'b0;
    push("mid_reset", mk(100, 320, 240, 0, 0, 0, 1));
    cyc(1);
    pop_check();
    rst_n = 1'b1;
    hold(16'h5030, 1, 4, "post_reset_mov", mk(100, 324, 240, 0, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
